time_counter: RTL and testbench
===============================

Name: time_counter

Overview:
BCD time-of-day counter for the digital clock. Divides the system clock down to a 1 Hz tick and keeps HH:MM:SS in 24-hour BCD. Accepts a synchronous time-set load. Its packed HHMM output is the current-time compare word consumed directly by the alarm `ring` stage (its `data_in_cmp` input).

Parameters:
- CLK_DIV, 50_000_000: clk cycles per second tick; must be ≥ 2.
- CNT_W, 26: prescaler width; must satisfy 2^CNT_W ≥ CLK_DIV.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- run  input  1  1 = timekeeping advances; 0 = prescaler and time frozen.
- load  input  1  synchronous time-set strobe, level-sampled each cycle.
- load_time  input  16  BCD {H1,H0,M1,M0}; 16'h1234 = 12:34.
- time_hhmm  output  16  current time, BCD {H1,H0,M1,M0}; feeds the alarm stage.
- time_ss  output  8  current seconds, BCD {S1,S0}.
- sec_pulse  output  1  one-cycle pulse on each seconds increment.
- min_pulse  output  1  one-cycle pulse on each minute rollover (SS 59→00).
- load_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (rst_n=0, async):
  - time_hhmm=16'h0000, time_ss=8'h00, sec_pulse=0, min_pulse=0, load_err=0, prescaler=0.
  - The block holds these values while rst_n is low.
  - The first tick after release arrives CLK_DIV cycles after the first enabled edge.
- Prescaler:
  - When run=1 and load=0, the prescaler increments each cycle.
  - At CLK_DIV-1 it wraps to 0 and generates an internal tick in the same cycle.
  - When run=0 the prescaler holds.
- Tick (registered, all outputs update on the same edge as the wrap):
  - S0 increments 0..9; at 9 it wraps to 0 and S1 increments.
  - S1 runs 0..5. SS 59→00 carries into minutes and asserts min_pulse.
  - Minutes: same BCD rule, 59→00 carries into hours.
  - Hours: H0 runs 0..9, except when H1=2, where H0 runs 0..3. 23→00 (carry dropped, no day output).
  - sec_pulse=1 for exactly that one cycle; min_pulse is coincident with sec_pulse on the rollover.
- Load (priority over tick and run):
  - Valid load_time means H1≤2, H0≤9, and when H1=2 then H0≤3, M1≤5, M0≤9.
  - Valid load: next edge sets time_hhmm=load_time, time_ss=00, prescaler=0. No sec_pulse/min_pulse that cycle, even if a tick would have occurred.
  - Invalid load: time and prescaler are unchanged (no tick that cycle either), and load_err pulses for 1 cycle.
  - Load held high for N cycles reloads every cycle. Counting resumes from prescaler=0 on the first cycle after load falls, so the first tick comes CLK_DIV cycles later.
  - A load sampled while run=0 still takes effect.
- Outputs are pure registers; no combinational path from inputs to outputs.
- Reset asserted mid-second clears everything immediately; no pulse is emitted.

Test Plan:
1. CLK_DIV=4. Release reset with run=1 → sec_pulse at cycles 4, 8, 12…; after 3 pulses time_ss=8'h03 and time_hhmm=16'h0000.
2. Load 16'h1234 (1 cycle), run=1 → next edge time_hhmm=16'h1234, time_ss=00. After 60 pulses time_hhmm=16'h1235, with min_pulse coincident with the 60th sec_pulse.
3. Load 16'h2359, run 60 ticks → time_hhmm=16'h0000, time_ss=00, single min_pulse. Load 16'h0959, 60 ticks → 16'h1000.
4. Load 16'h2400, then 16'h1260, then 16'h1A00 → load_err pulses each time; time_hhmm keeps its prior value.
5. run=0 for 20 cycles mid-second → no sec_pulse and prescaler frozen. On run=1, the remaining count completes before the next tick.
6. Load asserted on the same edge as a prescaler wrap → loaded value appears, sec_pulse=0. rst_n dropped mid-count → all outputs 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/time_counter.sv
// time_counter: 24-hour BCD time-of-day counter.
// Divides clk down to a one-second tick and keeps HH:MM:SS in BCD.
// A synchronous load sets HH:MM and clears SS; bad load values are rejected.
// time_hhmm is the compare word for the alarm ring stage.
module time_counter #(
  parameter int CLK_DIV = 50_000_000,
  parameter int CNT_W   = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        load,
  input  logic [15:0] load_time,
  output logic [15:0] time_hhmm,
  output logic [7:0]  time_ss,
  output logic        sec_pulse,
  output logic        min_pulse,
  output logic        load_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  // A load word is accepted only if it names a real 24-hour HH:MM.
  function automatic logic load_ok(input logic [15:0] t);
    logic hour_ok;
    logic min_ok;
    hour_ok = (t[15:12] <= 4'd2) && (t[11:8] <= 4'd9) &&
              ((t[15:12] != 4'd2) || (t[11:8] <= 4'd3));
    min_ok  = (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
    return hour_ok && min_ok;
  endfunction

  // Two-digit BCD increment over 00..59 (seconds and minutes).
  function automatic logic [7:0] bcd60_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      if (v[7:4] == 4'd5) begin
        r[7:4] = 4'd0;
      end else begin
        r[7:4] = v[7:4] + 4'd1;
      end
    end else begin
      r[7:4] = v[7:4];
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  // Two-digit BCD hour increment over 00..23; the day carry is dropped.
  function automatic logic [7:0] hour_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h23) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [15:0]      hhmm_nxt;
  logic [7:0]       ss_nxt;
  logic             sec_nxt;
  logic             min_nxt;
  logic             err_nxt;

  // Next-state: load beats tick and run; a tick ripples the BCD carry chain.
  always_comb begin
    cnt_nxt  = cnt;
    hhmm_nxt = time_hhmm;
    ss_nxt   = time_ss;
    sec_nxt  = 1'b0;
    min_nxt  = 1'b0;
    err_nxt  = 1'b0;
    if (load) begin
      if (load_ok(load_time)) begin
        hhmm_nxt = load_time;
        ss_nxt   = 8'h00;
        cnt_nxt  = {CNT_W{1'b0}};
      end else begin
        err_nxt  = 1'b1;
      end
    end else if (run) begin
      if (cnt == CNT_MAX) begin
        cnt_nxt = {CNT_W{1'b0}};
        sec_nxt = 1'b1;
        ss_nxt  = bcd60_inc(time_ss);
        if (time_ss == 8'h59) begin
          min_nxt        = 1'b1;
          hhmm_nxt[7:0]  = bcd60_inc(time_hhmm[7:0]);
          if (time_hhmm[7:0] == 8'h59) begin
            hhmm_nxt[15:8] = hour_inc(time_hhmm[15:8]);
          end else begin
            hhmm_nxt[15:8] = time_hhmm[15:8];
          end
        end else begin
          hhmm_nxt = time_hhmm;
        end
      end else begin
        cnt_nxt = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_nxt = cnt;
    end
  end

  // State and output registers; async reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= {CNT_W{1'b0}};
      time_hhmm <= 16'h0000;
      time_ss   <= 8'h00;
      sec_pulse <= 1'b0;
      min_pulse <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      time_hhmm <= hhmm_nxt;
      time_ss   <= ss_nxt;
      sec_pulse <= sec_nxt;
      min_pulse <= min_nxt;
      load_err  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_time_counter.sv
// Scoreboard bench for time_counter: a seconds-of-day reference model pushes
// expected pulse events into queues; a negedge monitor pops and compares them.
module tb_time_counter;

  localparam int DIV = 4;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        load;
  logic [15:0] load_time;
  logic [15:0] time_hhmm;
  logic [7:0]  time_ss;
  logic        sec_pulse;
  logic        min_pulse;
  logic        load_err;

  typedef struct {
    logic [15:0] hhmm;
    logic [7:0]  ss;
    logic        mn;
  } exp_t;

  exp_t        sec_q[$];
  logic [23:0] err_q[$];
  int          checks;
  int          failures;
  int          tod;
  int          presc;

  time_counter #(.CLK_DIV(DIV), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .load(load), .load_time(load_time),
    .time_hhmm(time_hhmm), .time_ss(time_ss), .sec_pulse(sec_pulse),
    .min_pulse(min_pulse), .load_err(load_err)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] to_bcd(input int t);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic bit valid_hhmm(input logic [15:0] v);
    int d3, d2, d1, d0;
    d3 = int'(v[15:12]);
    d2 = int'(v[11:8]);
    d1 = int'(v[7:4]);
    d0 = int'(v[3:0]);
    return (d3 <= 9) && (d2 <= 9) && (d1 <= 9) && (d0 <= 9) &&
           ((d3 * 10 + d2) < 24) && ((d1 * 10 + d0) < 60);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_now(input string name);
    logic [23:0] b;
    b = to_bcd(tod);
    chk(name, {8'h00, time_hhmm, time_ss}, {8'h00, b});
  endtask

  // Reference model: one clock edge worth of behaviour in seconds-of-day terms.
  task automatic model_step(input logic r, input logic l, input logic [15:0] lt);
    logic [23:0] b;
    exp_t e;
    if (l) begin
      if (valid_hhmm(lt)) begin
        tod   = (int'(lt[15:12]) * 10 + int'(lt[11:8])) * 3600 +
                (int'(lt[7:4]) * 10 + int'(lt[3:0])) * 60;
        presc = 0;
      end else begin
        err_q.push_back(to_bcd(tod));
      end
    end else if (r) begin
      if (presc == DIV - 1) begin
        presc = 0;
        tod   = (tod + 1) % 86400;
        b     = to_bcd(tod);
        e.hhmm = b[23:8];
        e.ss   = b[7:0];
        e.mn   = (tod % 60) == 0;
        sec_q.push_back(e);
      end else begin
        presc++;
      end
    end
  endtask

  task automatic step(input logic r, input logic l, input logic [15:0] lt);
    run       = r;
    load      = l;
    load_time = lt;
    model_step(r, l, lt);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every pulse the DUT presents must match the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    logic [23:0] t;
    if (rst_n) begin
      if (sec_pulse) begin
        checks++;
        if (sec_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_sec_pulse: time %h:%h", time_hhmm, time_ss);
        end else begin
          e = sec_q.pop_front();
          if (time_hhmm !== e.hhmm || time_ss !== e.ss || min_pulse !== e.mn) begin
            failures++;
            $display("FAIL tick: got %h:%h min=%b expected %h:%h min=%b",
                     time_hhmm, time_ss, min_pulse, e.hhmm, e.ss, e.mn);
          end
        end
      end else if (min_pulse) begin
        checks++;
        failures++;
        $display("FAIL lone_min_pulse: got 1 expected 0");
      end
      if (load_err) begin
        checks++;
        if (err_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_load_err: got 1 expected 0");
        end else begin
          t = err_q.pop_front();
          if ({time_hhmm, time_ss} !== t) begin
            failures++;
            $display("FAIL load_err_time: got %h expected %h", {time_hhmm, time_ss}, t);
          end
        end
      end
    end
  end

  initial begin
    logic [15:0] bad [3];
    logic [15:0] lt;
    int h, m;
    checks = 0; failures = 0; tod = 0; presc = 0;
    clk = 1'b0; rst_n = 1'b0; run = 1'b1; load = 1'b0; load_time = 16'h0000;
    bad[0] = 16'h2400; bad[1] = 16'h1260; bad[2] = 16'h1A00;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {5'd0, time_hhmm, time_ss, sec_pulse, min_pulse, load_err}, 32'h0);
    rst_n = 1'b1;

    // Free run from reset: three ticks.
    repeat (12) step(1'b1, 1'b0, 16'h0);
    chk("t1_ss", {24'h0, time_ss}, 32'h03);
    chk("t1_hhmm", {16'h0, time_hhmm}, 32'h0000);

    // Load 12:34 then one minute.
    step(1'b1, 1'b1, 16'h1234);
    chk("t2_load", {8'h0, time_hhmm, time_ss}, 32'h123400);
    repeat (60 * DIV) step(1'b1, 1'b0, 16'h0);
    chk("t2_minute", {16'h0, time_hhmm}, 32'h1235);

    // Day rollover and hour-digit carry.
    step(1'b1, 1'b1, 16'h2359);
    repeat (60 * DIV) step(1'b1, 1'b0, 16'h0);
    chk("t3_midnight", {8'h0, time_hhmm, time_ss}, 32'h000000);
    step(1'b1, 1'b1, 16'h0959);
    repeat (60 * DIV) step(1'b1, 1'b0, 16'h0);
    chk("t3_hour_carry", {16'h0, time_hhmm}, 32'h1000);

    // Invalid loads leave the time alone.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, bad[i]);
      chk("t4_reject", {16'h0, time_hhmm}, 32'h1000);
    end

    // Freeze mid-second, then resume.
    repeat (2) step(1'b1, 1'b0, 16'h0);
    repeat (20) step(1'b0, 1'b0, 16'h0);
    check_now("t5_frozen");
    repeat (2 * DIV) step(1'b1, 1'b0, 16'h0);
    check_now("t5_resumed");

    // Load on the cycle a wrap would have happened.
    for (int i = 0; i < 2 * DIV && presc != DIV - 1; i++) step(1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 16'h0815);
    chk("t6_load_on_wrap", {8'h0, time_hhmm, time_ss}, 32'h081500);
    chk("t6_no_pulse", {31'h0, sec_pulse}, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        h  = $urandom_range(23, 0);
        m  = $urandom_range(59, 0);
        lt = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
      end else begin
        lt = 16'($urandom);
      end
      step($urandom_range(9, 0) != 0, $urandom_range(24, 0) == 0, lt);
    end
    check_now("rand_end");

    // Async reset mid-count.
    step(1'b1, 1'b1, 16'h2158);
    repeat (DIV + 2) step(1'b1, 1'b0, 16'h0);
    @(negedge clk);
    chk("pre_reset_sec_q", sec_q.size(), 32'd0);
    chk("pre_reset_err_q", err_q.size(), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {5'd0, time_hhmm, time_ss, sec_pulse, min_pulse, load_err}, 32'h0);
    sec_q.delete();
    err_q.delete();
    tod = 0;
    presc = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2 * DIV + 1) step(1'b1, 1'b0, 16'h0);
    check_now("after_reset");

    @(negedge clk);
    #1;
    chk("final_sec_q", sec_q.size(), 32'd0);
    chk("final_err_q", err_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
